down_fifo_arb: RTL and testbench

DOWN_FIFO_ARB -- requirements
Module: down_fifo_arb

---
 rtl/down_fifo_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_down_fifo_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/down_fifo_arb.sv
// Two-requester round-robin burst writer into an external FIFO plus burst reader.
// Define DOWN_FIFO_ARB_STATS_EN to add per-requester write and read word counters.
module down_fifo_arb #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk_tb,
    input  logic                  tb_rst,
    input  logic                  s0_valid,
    input  logic [DATA_WIDTH-1:0] s0_data,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_ready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef DOWN_FIFO_ARB_STATS_EN
    output logic [ADDR_WIDTH:0]   level,
    output logic [31:0]           wr_cnt0,
    output logic [31:0]           wr_cnt1,
    output logic [31:0]           rd_cnt
`else
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_WLIM = (ADDR_WIDTH + 1)'(DEPTH - BURST_LEN);
    localparam logic [ADDR_WIDTH:0] L_BURST = (ADDR_WIDTH + 1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] L_LAST = ADDR_WIDTH'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_GNT0,
        W_GNT1
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rstate_t;

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic                  r_prio;
    logic [ADDR_WIDTH-1:0] r_wcnt;
    logic [ADDR_WIDTH-1:0] r_rcnt;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic w_can_start;
    logic w_pick1;
    logic w_wr0;
    logic w_wr1;
    logic w_wr_en;
    logic w_rd_en;
    logic w_rd_go;

    // New grants only when a whole burst is guaranteed to fit.
    assign w_can_start = (r_level <= L_WLIM) && !fifo_almost_full;
    assign w_pick1 = s1_valid && (!s0_valid || r_prio);

    assign s0_ready = (r_wstate == W_GNT0) && !fifo_full;
    assign s1_ready = (r_wstate == W_GNT1) && !fifo_full;
    assign w_wr0 = s0_valid && s0_ready;
    assign w_wr1 = s1_valid && s1_ready;
    assign w_wr_en = w_wr0 || w_wr1;

    assign fifo_wr_en = w_wr_en;
    assign fifo_wr_data = s1_ready ? s1_data : s0_data;

    assign w_rd_en = (r_rstate == R_BURST) && m_ready && !fifo_empty;
    assign w_rd_go = (r_level >= L_BURST) || (flush && (r_level != '0));
    assign fifo_rd_en = w_rd_en;

    assign m_valid = r_m_valid;
    assign m_data = r_m_data;
    assign level = r_level;

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_wstate <= W_IDLE;
            r_wcnt <= '0;
            r_prio <= 1'b0;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    r_wcnt <= '0;
                    if ((s0_valid || s1_valid) && w_can_start)
                        r_wstate <= w_pick1 ? W_GNT1 : W_GNT0;
                end
                W_GNT0: begin
                    if (!s0_valid) begin
                        r_wstate <= W_IDLE;
                        r_wcnt <= '0;
                        r_prio <= 1'b1;
                    end else if (w_wr0) begin
                        if (r_wcnt == L_LAST) begin
                            r_wstate <= W_IDLE;
                            r_wcnt <= '0;
                            r_prio <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                W_GNT1: begin
                    if (!s1_valid) begin
                        r_wstate <= W_IDLE;
                        r_wcnt <= '0;
                        r_prio <= 1'b0;
                    end else if (w_wr1) begin
                        if (r_wcnt == L_LAST) begin
                            r_wstate <= W_IDLE;
                            r_wcnt <= '0;
                            r_prio <= 1'b0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                    r_wcnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_rstate <= R_IDLE;
            r_rcnt <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    r_rcnt <= '0;
                    if (w_rd_go)
                        r_rstate <= R_BURST;
                end
                R_BURST: begin
                    if (w_rd_en) begin
                        if (r_rcnt == L_LAST) begin
                            r_rstate <= R_IDLE;
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end else if (fifo_empty) begin
                        r_rstate <= R_IDLE;
                        r_rcnt <= '0;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                    r_rcnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_level <= '0;
        end else begin
            unique case ({w_wr_en, w_rd_en})
                2'b10: if (r_level != L_DEPTH) r_level <= r_level + 1'b1;
                2'b01: if (r_level != '0) r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // The FIFO is show-ahead, so the head word is captured with the read strobe.
    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_m_valid <= 1'b0;
            r_m_data <= '0;
        end else begin
            r_m_valid <= w_rd_en;
            if (w_rd_en)
                r_m_data <= fifo_rd_data;
        end
    end

`ifdef DOWN_FIFO_ARB_STATS_EN
    logic [31:0] r_wr_cnt0;
    logic [31:0] r_wr_cnt1;
    logic [31:0] r_rd_cnt;

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            r_wr_cnt0 <= '0;
            r_wr_cnt1 <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr0) r_wr_cnt0 <= r_wr_cnt0 + 32'd1;
            if (w_wr1) r_wr_cnt1 <= r_wr_cnt1 + 32'd1;
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign wr_cnt0 = r_wr_cnt0;
    assign wr_cnt1 = r_wr_cnt1;
    assign rd_cnt = r_rd_cnt;
`endif

endmodule

// File: tb/tb_down_fifo_arb.sv
// Directed bench for down_fifo_arb with a show-ahead FIFO model.
// Requester data: s0 words 1,2,3..; s1 words 0x100001,0x100002..
module tb_down_fifo_arb;

    logic        clk_tb = 1'b0;
    logic        tb_rst;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [23:0] s0_data, s1_data;
    logic        fifo_wr_en, fifo_rd_en;
    logic [23:0] fifo_wr_data, fifo_rd_data;
    logic        fifo_full, fifo_almost_full, fifo_empty;
    logic        flush, m_ready, m_valid;
    logic [23:0] m_data;
    logic [8:0]  level;

    always #5 clk_tb = ~clk_tb;

    down_fifo_arb dut (
        .clk_tb(clk_tb), .tb_rst(tb_rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .m_ready(m_ready),
        .m_valid(m_valid), .m_data(m_data), .level(level)
    );

    int s0_lim, s1_lim, s0_acc, s1_acc;
    int gnt_n, prev_w, mv_n, rd_n, both_hi;
    int gnt_who [64];
    int gnt_len [64];
    logic [23:0] rx [512];
    logic [23:0] mem [256];
    logic [7:0]  f_wp, f_rp;
    logic [8:0]  f_cnt;
    int n_chk = 0;
    int n_pass = 0;

    assign s0_valid = (s0_acc < s0_lim);
    assign s1_valid = (s1_acc < s1_lim);
    assign s0_data = 24'(s0_acc + 1);
    assign s1_data = 24'(s1_acc + 32'h100001);
    assign fifo_full = (f_cnt == 9'd256);
    assign fifo_almost_full = (f_cnt >= 9'd248);
    assign fifo_empty = (f_cnt == 9'd0);
    assign fifo_rd_data = mem[f_rp];

    always @(posedge clk_tb or posedge tb_rst) begin
        int w;
        if (tb_rst) begin
            f_wp <= '0; f_rp <= '0; f_cnt <= '0;
            s0_acc <= 0; s1_acc <= 0; gnt_n <= 0; prev_w <= -1;
            mv_n <= 0; rd_n <= 0; both_hi <= 0;
        end else begin
            w = s0_ready ? 0 : (s1_ready ? 1 : -1);
            if (s0_ready && s1_ready) both_hi <= both_hi + 1;
            prev_w <= w;
            if (w >= 0 && w != prev_w && gnt_n < 64) begin
                gnt_who[gnt_n] <= w;
                gnt_len[gnt_n] <= fifo_wr_en ? 1 : 0;
                gnt_n <= gnt_n + 1;
            end else if (fifo_wr_en && gnt_n > 0) begin
                gnt_len[gnt_n-1] <= gnt_len[gnt_n-1] + 1;
            end
            if (fifo_wr_en) begin
                mem[f_wp] <= fifo_wr_data;
                f_wp <= f_wp + 8'd1;
                if (s0_ready) s0_acc <= s0_acc + 1;
                else s1_acc <= s1_acc + 1;
            end
            if (fifo_rd_en) begin
                f_rp <= f_rp + 8'd1;
                rd_n <= rd_n + 1;
            end
            f_cnt <= f_cnt + {8'd0, fifo_wr_en} - {8'd0, fifo_rd_en};
            if (m_valid) begin
                if (mv_n < 512) rx[mv_n] <= m_data;
                mv_n <= mv_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_tb);
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        m_ready = 1'b0; flush = 1'b0;
        s0_lim = 0; s1_lim = 0;
        cyc(2);
        tb_rst = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, input int n, input int budget);
        int k = 0;
        while (gnt_n < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(gnt_n >= n), 32'd1);
    endtask

    function automatic int order_errs(input int n, input int first);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (rx[i] != 24'(first + i)) e++;
        return e;
    endfunction

    initial begin
        int errs, k;
        tb_rst = 1'b0; m_ready = 1'b0; flush = 1'b0;
        s0_lim = 0; s1_lim = 0;
        #1 tb_rst = 1'b1;
        s0_lim = 1000; s1_lim = 1000;
        cyc(3);
        chk("rst_s0_ready", 32'(s0_ready), 0);
        chk("rst_s1_ready", 32'(s1_ready), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_level", 32'(level), 0);

        // single requester, 40 words
        do_reset();
        s0_lim = 40; m_ready = 1'b1;
        cyc(90);
        chk("t31_gnt_n", gnt_n, 3);
        chk("t31_len0", gnt_len[0], 16);
        chk("t31_len1", gnt_len[1], 16);
        chk("t31_len2", gnt_len[2], 8);
        errs = 0;
        for (int i = 0; i < 3; i++) if (gnt_who[i] != 0) errs++;
        chk("t31_who", errs, 0);
        chk("t31_mvalid", mv_n, 32);
        chk("t31_order", order_errs(32, 1), 0);
        chk("t31_level", 32'(level), 8);

        // both requesters continuously valid
        do_reset();
        s0_lim = 1000; s1_lim = 1000; m_ready = 1'b1;
        wait_gnt("t32_timeout", 5, 200);
        chk("t32_who0", gnt_who[0], 0);
        chk("t32_who1", gnt_who[1], 1);
        chk("t32_who2", gnt_who[2], 0);
        chk("t32_who3", gnt_who[3], 1);
        errs = 0;
        for (int i = 0; i < 4; i++) if (gnt_len[i] != 16) errs++;
        chk("t32_lens", errs, 0);
        chk("t32_both_hi", both_hi, 0);

        // partial burst drained by flush
        do_reset();
        s0_lim = 8; m_ready = 1'b1;
        cyc(15);
        chk("t33_pre_level", 32'(level), 8);
        chk("t33_pre_mv", mv_n, 0);
        flush = 1'b1;
        cyc(20);
        flush = 1'b0;
        cyc(5);
        chk("t33_mvalid", mv_n, 8);
        chk("t33_order", order_errs(8, 1), 0);
        chk("t33_level", 32'(level), 0);
        chk("t33_rd_idle", rd_n, 8);

        // s1 ends its grant early, then both contend
        do_reset();
        s1_lim = 5;
        cyc(12);
        s0_lim = 3; s1_lim = 1000;
        wait_gnt("t35_timeout", 3, 60);
        chk("t35_who0", gnt_who[0], 1);
        chk("t35_len0", gnt_len[0], 5);
        chk("t35_who1", gnt_who[1], 0);
        chk("t35_len1", gnt_len[1], 3);
        chk("t35_who2", gnt_who[2], 1);

        // fill to 256 with reads stalled
        do_reset();
        s0_lim = 256;
        k = 0;
        while (level != 9'd256 && k < 400) begin
            cyc(1);
            k++;
        end
        chk("t34_full", 32'(level), 256);
        s1_lim = 1000;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (s0_ready || s1_ready || fifo_rd_en) errs++;
        end
        chk("t34_stall", errs, 0);
        chk("t34_no_rd", rd_n, 0);
        s1_lim = 0; m_ready = 1'b1;
        k = 0;
        while (rd_n < 16 && k < 40) begin
            cyc(1);
            k++;
        end
        m_ready = 1'b0;
        cyc(5);
        chk("t34_reads", rd_n, 16);
        chk("t34_level", 32'(level), 240);
        chk("t34_order", order_errs(16, 1), 0);

        // reset in the middle of write and read bursts
        do_reset();
        s0_lim = 1000; m_ready = 1'b1;
        cyc(25);
        chk("t36_pre_wr", 32'(fifo_wr_en), 1);
        chk("t36_pre_rd", 32'(fifo_rd_en), 1);
        tb_rst = 1'b1;
        #1;
        chk("t36_s0_ready", 32'(s0_ready), 0);
        chk("t36_wr_en", 32'(fifo_wr_en), 0);
        chk("t36_rd_en", 32'(fifo_rd_en), 0);
        chk("t36_m_valid", 32'(m_valid), 0);
        chk("t36_level", 32'(level), 0);
        s1_lim = 1000;
        cyc(1);
        tb_rst = 1'b0;
        wait_gnt("t36_timeout", 1, 20);
        chk("t36_first_gnt", gnt_who[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
